// File: rtl/mycpu_pkg.sv
// Shared definitions for the mycpu datapath: PC select encoding driven by the
// control unit and the width of the PC-relative branch offset field.
package mycpu_pkg;

    typedef enum logic [1:0] {
        PS_HOLD = 2'b00,
        PS_INC  = 2'b01,
        PS_BRA  = 2'b10,
        PS_JMP  = 2'b11
    } pc_sel_t;

    localparam int BR_OFF_W = 6;

endpackage

// File: rtl/pc_ir_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over
// increment, and the count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_in,
    input  logic         inc_in,
    output logic [W-1:0] cnt_out
);

    localparam logic [W-1:0] CNT_ONE = W'(1);
    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear first, then increment only while below the ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_in) begin
            cnt_d = '0;
        end else if (inc_in && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Count register, cleared immediately on reset assertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_out = cnt_q;

endmodule

// File: rtl/pc_ir_unit.sv
// Program counter and instruction register of the mycpu datapath, with
// saturating counters for fetched instructions and taken branches/jumps.
module pc_ir_unit #(
    parameter int PC_W  = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       ps_in,
    input  logic             il_in,
    input  logic [15:0]      ra_in,
    input  logic [15:0]      imem_data_in,
    input  logic             clr_cnt_in,
    output logic [PC_W-1:0]  imem_addr_out,
    output logic [PC_W-1:0]  pc_out,
    output logic [15:0]      ins_out,
    output logic [CNT_W-1:0] ins_cnt_out,
    output logic [CNT_W-1:0] br_cnt_out
);

    import mycpu_pkg::*;

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    logic [PC_W-1:0]     pc_q;
    logic [PC_W-1:0]     pc_d;
    logic [15:0]         ins_q;
    logic [15:0]         ins_d;
    pc_sel_t             ps_sel;
    logic [BR_OFF_W-1:0] br_off;
    logic [15:0]         br_off_ext;
    logic [PC_W-1:0]     br_off_pc;
    logic                unused_bits;

    assign ps_sel = pc_sel_t'(ps_in);

    // Branch offset is split around the destination register field; it is
    // sign-extended to 16 bits and then cut to PC width, which keeps the
    // add modulo 2^PC_W even when PC_W is narrower than the offset.
    assign br_off     = {ins_q[8:6], ins_q[2:0]};
    assign br_off_ext = {{(16-BR_OFF_W){br_off[BR_OFF_W-1]}}, br_off};
    assign br_off_pc  = br_off_ext[PC_W-1:0];

    // Bits above PC_W of the jump source and offset are intentionally dropped.
    assign unused_bits = ^{ra_in, br_off_ext};

    // Next-PC mux; branch base is the un-incremented PC of the branch itself.
    always_comb begin
        pc_d = pc_q;
        case (ps_sel)
            PS_HOLD: pc_d = pc_q;
            PS_INC:  pc_d = pc_q + PC_ONE;
            PS_BRA:  pc_d = pc_q + br_off_pc;
            PS_JMP:  pc_d = ra_in[PC_W-1:0];
            default: pc_d = pc_q;
        endcase
    end

    // IR captures the word at the current (pre-update) PC on a load strobe.
    always_comb begin
        ins_d = ins_q;
        if (il_in) begin
            ins_d = imem_data_in;
        end
    end

    // PC and IR registers; reset forces both to zero without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= '0;
            ins_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ins_q <= ins_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_ins_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_in  (clr_cnt_in),
        .inc_in  (il_in),
        .cnt_out (ins_cnt_out)
    );

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_in  (clr_cnt_in),
        .inc_in  (ps_in[1]),
        .cnt_out (br_cnt_out)
    );

    assign imem_addr_out = pc_q;
    assign pc_out        = pc_q;
    assign ins_out       = ins_q;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Scoreboard bench for pc_ir_unit: three instances with different widths share
// one stimulus stream; expected values are queued and checked by a monitor.
module tb_pc_ir_unit;

    localparam logic [1:0] PS_HOLD_V = 2'b00;
    localparam logic [1:0] PS_INC_V  = 2'b01;
    localparam logic [1:0] PS_BRA_V  = 2'b10;
    localparam logic [1:0] PS_JMP_V  = 2'b11;

    localparam int DUT_A = 0;
    localparam int DUT_B = 1;
    localparam int DUT_C = 2;

    localparam int F_PC  = 0;
    localparam int F_IR  = 1;
    localparam int F_INS = 2;
    localparam int F_BR  = 3;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ps_drv;
    logic        il_drv;
    logic [15:0] ra_drv;
    logic        clr_drv;
    logic [15:0] data_drv;

    logic [15:0] addr_a;
    logic [15:0] pc_a;
    logic [15:0] ir_a;
    logic [15:0] imem_a;
    logic [31:0] ins_cnt_a;
    logic [31:0] br_cnt_a;

    logic [3:0]  addr_b;
    logic [3:0]  pc_b;
    logic [15:0] ir_b;
    logic [15:0] imem_b;
    logic [1:0]  ins_cnt_b;
    logic [1:0]  br_cnt_b;

    logic [11:0] addr_c;
    logic [11:0] pc_c;
    logic [15:0] ir_c;
    logic [15:0] imem_c;
    logic [31:0] ins_cnt_c;
    logic [31:0] br_cnt_c;

    typedef struct {
        string       name;
        int          dut;
        int          field;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    event sample_now;
    int   n_compared;
    int   n_mismatched;

    // Instruction memory: word 5 holds 0x0E00, every other address returns data_drv.
    assign imem_a = (addr_a == 16'h0005) ? 16'h0E00 : data_drv;
    assign imem_b = (addr_b == 4'h5)     ? 16'h0E00 : data_drv;
    assign imem_c = (addr_c == 12'h005)  ? 16'h0E00 : data_drv;

    pc_ir_unit #(.PC_W(16), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .ps_in(ps_drv), .il_in(il_drv), .ra_in(ra_drv),
        .imem_data_in(imem_a), .clr_cnt_in(clr_drv), .imem_addr_out(addr_a),
        .pc_out(pc_a), .ins_out(ir_a), .ins_cnt_out(ins_cnt_a), .br_cnt_out(br_cnt_a)
    );

    pc_ir_unit #(.PC_W(4), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ps_in(ps_drv), .il_in(il_drv), .ra_in(ra_drv),
        .imem_data_in(imem_b), .clr_cnt_in(clr_drv), .imem_addr_out(addr_b),
        .pc_out(pc_b), .ins_out(ir_b), .ins_cnt_out(ins_cnt_b), .br_cnt_out(br_cnt_b)
    );

    pc_ir_unit #(.PC_W(12), .CNT_W(32)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .ps_in(ps_drv), .il_in(il_drv), .ra_in(ra_drv),
        .imem_data_in(imem_c), .clr_cnt_in(clr_drv), .imem_addr_out(addr_c),
        .pc_out(pc_c), .ins_out(ir_c), .ins_cnt_out(ins_cnt_c), .br_cnt_out(br_cnt_c)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] read_out(input int dut, input int field);
        logic [31:0] v;
        v = '0;
        case (dut)
            DUT_A: case (field)
                F_PC:  v = {16'h0, pc_a};
                F_IR:  v = {16'h0, ir_a};
                F_INS: v = ins_cnt_a;
                default: v = br_cnt_a;
            endcase
            DUT_B: case (field)
                F_PC:  v = {28'h0, pc_b};
                F_IR:  v = {16'h0, ir_b};
                F_INS: v = {30'h0, ins_cnt_b};
                default: v = {30'h0, br_cnt_b};
            endcase
            default: case (field)
                F_PC:  v = {20'h0, pc_c};
                F_IR:  v = {16'h0, ir_c};
                F_INS: v = ins_cnt_c;
                default: v = br_cnt_c;
            endcase
        endcase
        return v;
    endfunction

    // One clock of stimulus: drive on the falling edge, return just after the
    // rising edge, then park the inputs at idle.
    task automatic applyStimulus(input logic [1:0] ps, input logic il, input logic [15:0] ra,
                                 input logic clr, input logic [15:0] data);
        @(negedge clk);
        ps_drv   = ps;
        il_drv   = il;
        ra_drv   = ra;
        clr_drv  = clr;
        data_drv = data;
        @(posedge clk);
        #1;
        ps_drv   = PS_HOLD_V;
        il_drv   = 1'b0;
        ra_drv   = 16'h0;
        clr_drv  = 1'b0;
        data_drv = 16'h0;
    endtask

    // Queue an expected output value for the monitor.
    task automatic checkOutput(input string name, input int dut, input int field,
                               input logic [31:0] exp);
        exp_t e;
        e.name  = name;
        e.dut   = dut;
        e.field = field;
        e.exp   = exp;
        sb_q.push_back(e);
    endtask

    // Monitor: drains the scoreboard on each falling edge or on demand.
    initial begin : monitor
        exp_t        e;
        logic [31:0] act;
        n_compared   = 0;
        n_mismatched = 0;
        forever begin
            @(negedge clk or sample_now);
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = read_out(e.dut, e.field);
                n_compared++;
                if (act !== e.exp) begin
                    n_mismatched++;
                    $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", e.name, act, e.exp);
                end
            end
        end
    end

    // Directed sequence with hand-computed expectations.
    initial begin : stimulus
        int wait_cycles;
        rst_n    = 1'b0;
        ps_drv   = PS_HOLD_V;
        il_drv   = 1'b0;
        ra_drv   = 16'h0;
        clr_drv  = 1'b0;
        data_drv = 16'h0;

        #3;
        checkOutput("rst0_pc", DUT_A, F_PC, 32'h0);
        checkOutput("rst0_ir", DUT_A, F_IR, 32'h0);
        checkOutput("rst0_ins", DUT_A, F_INS, 32'h0);
        checkOutput("rst0_br", DUT_A, F_BR, 32'h0);
        -> sample_now;
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(PS_JMP_V, 1'b0, 16'h0012, 1'b0, 16'h0);
        checkOutput("jmp12_pc", DUT_A, F_PC, 32'h0012);
        checkOutput("jmp12_br", DUT_A, F_BR, 32'h1);

        // Mid-run reset between clock edges must clear state at once.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_pc", DUT_A, F_PC, 32'h0);
        checkOutput("rstmid_ir", DUT_A, F_IR, 32'h0);
        checkOutput("rstmid_ins", DUT_A, F_INS, 32'h0);
        checkOutput("rstmid_br", DUT_A, F_BR, 32'h0);
        -> sample_now;
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(PS_HOLD_V, 1'b1, 16'h0, 1'b0, 16'h1234);
        checkOutput("fetch_ir", DUT_A, F_IR, 32'h1234);
        checkOutput("fetch_ins", DUT_A, F_INS, 32'h1);
        checkOutput("fetch_pc", DUT_A, F_PC, 32'h0);

        applyStimulus(PS_JMP_V, 1'b0, 16'h000F, 1'b0, 16'h0);
        checkOutput("b_jmpf_pc", DUT_B, F_PC, 32'hF);
        applyStimulus(PS_INC_V, 1'b0, 16'h0, 1'b0, 16'h0);
        checkOutput("b_incwrap_pc", DUT_B, F_PC, 32'h0);
        checkOutput("a_inc_pc", DUT_A, F_PC, 32'h0010);
        checkOutput("a_inc_br", DUT_A, F_BR, 32'h1);

        applyStimulus(PS_HOLD_V, 1'b1, 16'h0, 1'b0, 16'h01C6);
        checkOutput("a_ldm2_ir", DUT_A, F_IR, 32'h01C6);
        checkOutput("a_ldm2_ins", DUT_A, F_INS, 32'h2);
        applyStimulus(PS_BRA_V, 1'b0, 16'h0, 1'b0, 16'h0);
        checkOutput("a_bram2_pc", DUT_A, F_PC, 32'h000E);
        checkOutput("a_bram2_br", DUT_A, F_BR, 32'h2);

        applyStimulus(PS_JMP_V, 1'b0, 16'hFFF0, 1'b0, 16'h0);
        checkOutput("a_jmpfff0_pc", DUT_A, F_PC, 32'hFFF0);
        applyStimulus(PS_HOLD_V, 1'b1, 16'h0, 1'b0, 16'h00C7);
        checkOutput("a_ldp31_ir", DUT_A, F_IR, 32'h00C7);
        applyStimulus(PS_BRA_V, 1'b0, 16'h0, 1'b0, 16'h0);
        checkOutput("a_brap31_pc", DUT_A, F_PC, 32'h000F);
        checkOutput("a_brap31_br", DUT_A, F_BR, 32'h4);
        checkOutput("b_brap31_pc", DUT_B, F_PC, 32'hF);

        applyStimulus(PS_HOLD_V, 1'b0, 16'h0, 1'b1, 16'h0);
        checkOutput("clr_a_br", DUT_A, F_BR, 32'h0);
        checkOutput("clr_c_br", DUT_C, F_BR, 32'h0);
        applyStimulus(PS_JMP_V, 1'b0, 16'hABCD, 1'b0, 16'h0);
        checkOutput("c_jmp_pc", DUT_C, F_PC, 32'hBCD);
        checkOutput("c_jmp_br", DUT_C, F_BR, 32'h1);
        checkOutput("a_jmp_pc", DUT_A, F_PC, 32'hABCD);
        applyStimulus(PS_INC_V, 1'b0, 16'h0, 1'b0, 16'h0);
        checkOutput("c_inc_pc", DUT_C, F_PC, 32'hBCE);
        checkOutput("c_inc_br", DUT_C, F_BR, 32'h1);

        applyStimulus(PS_HOLD_V, 1'b1, 16'h0, 1'b0, 16'h0);
        checkOutput("b_sat1", DUT_B, F_INS, 32'h1);
        applyStimulus(PS_HOLD_V, 1'b1, 16'h0, 1'b0, 16'h0);
        checkOutput("b_sat2", DUT_B, F_INS, 32'h2);
        applyStimulus(PS_HOLD_V, 1'b1, 16'h0, 1'b0, 16'h0);
        checkOutput("b_sat3", DUT_B, F_INS, 32'h3);
        applyStimulus(PS_HOLD_V, 1'b1, 16'h0, 1'b0, 16'h0);
        checkOutput("b_sat4", DUT_B, F_INS, 32'h3);
        applyStimulus(PS_HOLD_V, 1'b1, 16'h0, 1'b0, 16'h0);
        checkOutput("b_sat5", DUT_B, F_INS, 32'h3);
        checkOutput("a_ins5", DUT_A, F_INS, 32'h5);
        applyStimulus(PS_HOLD_V, 1'b1, 16'h0, 1'b1, 16'h0);
        checkOutput("b_clrwin_ins", DUT_B, F_INS, 32'h0);
        checkOutput("a_clrwin_ins", DUT_A, F_INS, 32'h0);
        checkOutput("b_clrwin_br", DUT_B, F_BR, 32'h0);

        applyStimulus(PS_JMP_V, 1'b0, 16'h0005, 1'b0, 16'h0);
        checkOutput("a_jmp5_pc", DUT_A, F_PC, 32'h0005);
        applyStimulus(PS_INC_V, 1'b1, 16'h0, 1'b0, 16'h7777);
        checkOutput("a_sim_ir", DUT_A, F_IR, 32'h0E00);
        checkOutput("a_sim_pc", DUT_A, F_PC, 32'h0006);
        checkOutput("a_sim_ins", DUT_A, F_INS, 32'h1);
        checkOutput("b_sim_ir", DUT_B, F_IR, 32'h0E00);
        checkOutput("b_sim_pc", DUT_B, F_PC, 32'h6);

        applyStimulus(PS_JMP_V, 1'b0, 16'h0000, 1'b1, 16'h0);
        checkOutput("a_clrjmp_br", DUT_A, F_BR, 32'h0);
        checkOutput("a_clrjmp_pc", DUT_A, F_PC, 32'h0);

        wait_cycles = 0;
        while ((sb_q.size() > 0) && (wait_cycles < 20)) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (sb_q.size() > 0) begin
            n_mismatched++;
            $display("[TB] FAIL drain: actual %0d pending required 0 pending", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
